// File: rtl/ec_error_monitor18x10_if.sv
// Word bus between the 18x10 corrector and its error monitor: corrected digits
// and flags in, registered digits and word class out.
interface ec_error_monitor18x10_if #(
    parameter int DATA_WIDTH = 18
);
    logic                  datavalid_in;
    logic                  cor_error;
    logic                  non_cor_error;
    logic                  mal_error;
    logic [19:0]           err_digs;
    logic [DATA_WIDTH-1:0] Dig_in_0_, Dig_in_1_, Dig_in_2_, Dig_in_3_, Dig_in_4_;
    logic [DATA_WIDTH-1:0] Dig_in_5_, Dig_in_6_, Dig_in_7_, Dig_in_8_, Dig_in_9_;

    logic                  datavalid_out;
    logic [1:0]            err_class_out;
    logic [DATA_WIDTH-1:0] out_0_, out_1_, out_2_, out_3_, out_4_;
    logic [DATA_WIDTH-1:0] out_5_, out_6_, out_7_, out_8_, out_9_;

    modport master (
        output datavalid_in, cor_error, non_cor_error, mal_error, err_digs,
        output Dig_in_0_, Dig_in_1_, Dig_in_2_, Dig_in_3_, Dig_in_4_,
        output Dig_in_5_, Dig_in_6_, Dig_in_7_, Dig_in_8_, Dig_in_9_,
        input  datavalid_out, err_class_out,
        input  out_0_, out_1_, out_2_, out_3_, out_4_,
        input  out_5_, out_6_, out_7_, out_8_, out_9_
    );

    modport slave (
        input  datavalid_in, cor_error, non_cor_error, mal_error, err_digs,
        input  Dig_in_0_, Dig_in_1_, Dig_in_2_, Dig_in_3_, Dig_in_4_,
        input  Dig_in_5_, Dig_in_6_, Dig_in_7_, Dig_in_8_, Dig_in_9_,
        output datavalid_out, err_class_out,
        output out_0_, out_1_, out_2_, out_3_, out_4_,
        output out_5_, out_6_, out_7_, out_8_, out_9_
    );
endinterface

// File: rtl/ec_error_monitor18x10.sv
// Error monitor for the 18x10 corrector: 1-cycle pass-through, saturating statistics
// and a show-ahead event FIFO. Define EC_MON_DROP_UNCORRECTABLE_EN to invalidate
// non_cor/mal words on datavalid_out.
module ec_error_monitor18x10 #(
    parameter int DATA_WIDTH = 18,
    parameter int CNT_WIDTH  = 32,
    parameter int FIFO_AW    = 3
) (
    input  logic                 clk,
    input  logic                 sclr,
    ec_error_monitor18x10_if.slave bus,
    input  logic                 cnt_clr,
    input  logic                 evt_rd,
    output logic [CNT_WIDTH-1:0] cnt_words,
    output logic [CNT_WIDTH-1:0] cnt_cor,
    output logic [CNT_WIDTH-1:0] cnt_noncor,
    output logic [CNT_WIDTH-1:0] cnt_mal,
    output logic [9:0]           dig_hits,
    output logic                 evt_valid,
    output logic [37:0]          evt_data,
    output logic                 evt_overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = DEPTH[FIFO_AW:0];
    localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] STAT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] w_dig_in  [10];
    logic [DATA_WIDTH-1:0] r_dig_out [10];
    logic                  r_dv;
    logic [1:0]            r_class;
    logic [1:0]            w_class;
    logic                  w_event;
    logic                  w_dv_next;
    logic [9:0]            w_dig_flag;
    logic [9:0]            r_dig_hits;

    assign w_dig_in[0] = bus.Dig_in_0_;
    assign w_dig_in[1] = bus.Dig_in_1_;
    assign w_dig_in[2] = bus.Dig_in_2_;
    assign w_dig_in[3] = bus.Dig_in_3_;
    assign w_dig_in[4] = bus.Dig_in_4_;
    assign w_dig_in[5] = bus.Dig_in_5_;
    assign w_dig_in[6] = bus.Dig_in_6_;
    assign w_dig_in[7] = bus.Dig_in_7_;
    assign w_dig_in[8] = bus.Dig_in_8_;
    assign w_dig_in[9] = bus.Dig_in_9_;

    assign bus.out_0_ = r_dig_out[0];
    assign bus.out_1_ = r_dig_out[1];
    assign bus.out_2_ = r_dig_out[2];
    assign bus.out_3_ = r_dig_out[3];
    assign bus.out_4_ = r_dig_out[4];
    assign bus.out_5_ = r_dig_out[5];
    assign bus.out_6_ = r_dig_out[6];
    assign bus.out_7_ = r_dig_out[7];
    assign bus.out_8_ = r_dig_out[8];
    assign bus.out_9_ = r_dig_out[9];
    assign bus.datavalid_out = r_dv;
    assign bus.err_class_out = r_class;

    // Priority mal > non_cor > cor; flags mean nothing without datavalid_in.
    always_comb begin
        w_class = 2'b00;
        if (bus.datavalid_in) begin
            if (bus.mal_error)          w_class = 2'b11;
            else if (bus.non_cor_error) w_class = 2'b10;
            else if (bus.cor_error)     w_class = 2'b01;
        end
    end
    assign w_event = (w_class != 2'b00);

`ifdef EC_MON_DROP_UNCORRECTABLE_EN
    assign w_dv_next = bus.datavalid_in & ~w_class[1];
`else
    assign w_dv_next = bus.datavalid_in;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_flag
            assign w_dig_flag[gi] = |bus.err_digs[2*gi +: 2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_dv    <= 1'b0;
            r_class <= 2'b00;
            for (int i = 0; i < 10; i++) r_dig_out[i] <= '0;
        end else begin
            r_dv    <= w_dv_next;
            r_class <= w_class;
            for (int i = 0; i < 10; i++) r_dig_out[i] <= w_dig_in[i];
        end
    end

    // Statistics: index 0 words, 1 cor, 2 non_cor, 3 mal.
    logic [CNT_WIDTH-1:0] r_cnt      [4];
    logic [CNT_WIDTH-1:0] w_cnt_next [4];
    logic [3:0]           w_cnt_inc;

    assign w_cnt_inc = {w_class == 2'b11, w_class == 2'b10, w_class == 2'b01, bus.datavalid_in};

    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            assign w_cnt_next[gi] = (w_cnt_inc[gi] && (r_cnt[gi] != '1)) ?
                                    r_cnt[gi] + STAT_ONE : r_cnt[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (sclr || cnt_clr) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
            r_dig_hits <= '0;
        end else begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_next[i];
            if (w_class == 2'b01) r_dig_hits <= r_dig_hits | w_dig_flag;
        end
    end

    assign cnt_words  = r_cnt[0];
    assign cnt_cor    = r_cnt[1];
    assign cnt_noncor = r_cnt[2];
    assign cnt_mal    = r_cnt[3];
    assign dig_hits   = r_dig_hits;

    logic [37:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic [37:0]        w_entry;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = evt_rd & ~w_empty;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_entry = {w_class, bus.err_digs, r_cnt[0][15:0]};

    always_ff @(posedge clk) begin
        if (w_push && !sclr) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
            if (w_event && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // Show-ahead head; forced to zero when empty so stale memory never leaks out.
    assign evt_valid    = ~w_empty;
    assign evt_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign evt_overflow = r_overflow;
endmodule

// File: tb/tb_ec_error_monitor18x10.sv
// Randomized bench for ec_error_monitor18x10 against a queue-based behavioural model.
module tb_ec_error_monitor18x10;
    logic        clk = 1'b0;
    logic        sclr;
    logic        cnt_clr;
    logic        evt_rd;
    logic [31:0] cnt_words, cnt_cor, cnt_noncor, cnt_mal;
    logic [9:0]  dig_hits;
    logic        evt_valid;
    logic [37:0] evt_data;
    logic        evt_overflow;

    ec_error_monitor18x10_if #(.DATA_WIDTH(18)) bus ();

    ec_error_monitor18x10 #(.DATA_WIDTH(18), .CNT_WIDTH(32), .FIFO_AW(3)) dut (
        .clk(clk), .sclr(sclr), .bus(bus), .cnt_clr(cnt_clr), .evt_rd(evt_rd),
        .cnt_words(cnt_words), .cnt_cor(cnt_cor), .cnt_noncor(cnt_noncor), .cnt_mal(cnt_mal),
        .dig_hits(dig_hits), .evt_valid(evt_valid), .evt_data(evt_data),
        .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    longint      m_words, m_cor, m_nc, m_mal;
    logic [9:0]  m_hits;
    logic [37:0] m_q [$];
    logic        m_ovf;
    logic        m_dv;
    logic [1:0]  m_cls;
    logic [17:0] m_out [10];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_dig(input int k, input logic [17:0] v);
        case (k)
            0: bus.Dig_in_0_ = v;  1: bus.Dig_in_1_ = v;  2: bus.Dig_in_2_ = v;
            3: bus.Dig_in_3_ = v;  4: bus.Dig_in_4_ = v;  5: bus.Dig_in_5_ = v;
            6: bus.Dig_in_6_ = v;  7: bus.Dig_in_7_ = v;  8: bus.Dig_in_8_ = v;
            default: bus.Dig_in_9_ = v;
        endcase
    endtask

    function automatic logic [17:0] get_out(input int k);
        case (k)
            0: return bus.out_0_;  1: return bus.out_1_;  2: return bus.out_2_;
            3: return bus.out_3_;  4: return bus.out_4_;  5: return bus.out_5_;
            6: return bus.out_6_;  7: return bus.out_7_;  8: return bus.out_8_;
            default: return bus.out_9_;
        endcase
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v >= 64'hFFFF_FFFF) ? v : v + 1;
    endfunction

    // One clock: drive the word, let the edge happen, advance the model, compare everything.
    task automatic step(input logic vld, input logic c, input logic n, input logic m,
                        input logic [19:0] ed, input logic clr, input logic rd, input logic rst);
        logic [17:0] d [10];
        logic [1:0]  cls;
        logic [9:0]  flags;
        logic [15:0] ts;
        bit          pop;
        for (int i = 0; i < 10; i++) begin
            d[i] = 18'($urandom);
            set_dig(i, d[i]);
        end
        bus.datavalid_in = vld; bus.cor_error = c; bus.non_cor_error = n; bus.mal_error = m;
        bus.err_digs = ed; cnt_clr = clr; evt_rd = rd; sclr = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            m_words = 0; m_cor = 0; m_nc = 0; m_mal = 0; m_hits = '0; m_ovf = 1'b0;
            m_q.delete(); m_dv = 1'b0; m_cls = 2'b00;
            for (int i = 0; i < 10; i++) m_out[i] = '0;
        end else begin
            cls = !vld ? 2'd0 : m ? 2'd3 : n ? 2'd2 : c ? 2'd1 : 2'd0;
            for (int k = 0; k < 10; k++) flags[k] = (ed[2*k +: 2] != 2'b00);
            ts  = 16'(m_words % 65536);
            pop = rd && (m_q.size() > 0);
            if (pop) void'(m_q.pop_front());
            if (cls != 2'd0) begin
                if (m_q.size() < 8) m_q.push_back({cls, ed, ts});
                else m_ovf = 1'b1;
            end
            if (clr) begin
                m_words = 0; m_cor = 0; m_nc = 0; m_mal = 0; m_hits = '0;
            end else if (vld) begin
                m_words = sat_inc(m_words);
                if (cls == 2'd1) begin m_cor = sat_inc(m_cor); m_hits = m_hits | flags; end
                if (cls == 2'd2) m_nc  = sat_inc(m_nc);
                if (cls == 2'd3) m_mal = sat_inc(m_mal);
            end
            m_dv = vld;
`ifdef EC_MON_DROP_UNCORRECTABLE_EN
            if (cls >= 2'd2) m_dv = 1'b0;
`endif
            m_cls = cls;
            for (int i = 0; i < 10; i++) m_out[i] = d[i];
        end
        check_eq("datavalid_out", 64'(bus.datavalid_out), 64'(m_dv));
        check_eq("err_class_out", 64'(bus.err_class_out), 64'(m_cls));
        for (int i = 0; i < 10; i++) check_eq($sformatf("out_%0d", i), 64'(get_out(i)), 64'(m_out[i]));
        check_eq("cnt_words", 64'(cnt_words), 64'(m_words));
        check_eq("cnt_cor", 64'(cnt_cor), 64'(m_cor));
        check_eq("cnt_noncor", 64'(cnt_noncor), 64'(m_nc));
        check_eq("cnt_mal", 64'(cnt_mal), 64'(m_mal));
        check_eq("dig_hits", 64'(dig_hits), 64'(m_hits));
        check_eq("evt_valid", 64'(evt_valid), 64'(m_q.size() > 0));
        check_eq("evt_data", 64'(evt_data), (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
        check_eq("evt_overflow", 64'(evt_overflow), 64'(m_ovf));
        $display("t=%0t vld=%0b cls=%0d clr=%0b rd=%0b rst=%0b words=%0d fifo=%0d ovf=%0b",
                 $time, vld, m_cls, clr, rd, rst, m_words, m_q.size(), m_ovf);
    endtask

    task automatic idle(input logic clr, input logic rd, input logic rst);
        step(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, clr, rd, rst);
    endtask

    initial begin
        logic [19:0] ed;
        m_words = 0; m_cor = 0; m_nc = 0; m_mal = 0; m_hits = '0; m_ovf = 1'b0;
        m_dv = 1'b0; m_cls = 2'b00;
        for (int i = 0; i < 10; i++) m_out[i] = '0;

        idle(1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b0, 1'b1);
        check_eq("reset_words", 64'(cnt_words), 64'd0);
        check_eq("reset_evt_valid", 64'(evt_valid), 64'd0);

        // Clean stream
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
        check_eq("clean_words", 64'(cnt_words), 64'd100);
        check_eq("clean_no_evt", 64'(evt_valid), 64'd0);

        // Correctable event on word index 5, then a mal+cor word
        idle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 20'h0000C, 1'b0, 1'b0, 1'b0);
        check_eq("w5_head", 64'(evt_data), 64'({2'b01, 20'h0000C, 16'd5}));
        check_eq("w5_cnt_cor", 64'(cnt_cor), 64'd1);
        check_eq("w5_dig_hits", 64'(dig_hits), 64'b0000000010);
        step(1'b1, 1'b1, 1'b0, 1'b1, 20'h0000C, 1'b0, 1'b0, 1'b0);
        check_eq("mal_class", 64'(bus.err_class_out), 64'd3);
        check_eq("mal_cnt_mal", 64'(cnt_mal), 64'd1);
        check_eq("mal_cnt_cor", 64'(cnt_cor), 64'd1);
`ifdef EC_MON_DROP_UNCORRECTABLE_EN
        check_eq("mal_dv", 64'(bus.datavalid_out), 64'd0);
`else
        check_eq("mal_dv", 64'(bus.datavalid_out), 64'd1);
`endif

        // 9 events without reads, then 9 pops
        idle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 20'($urandom), 1'b0, 1'b0, 1'b0);
        check_eq("ovf_set", 64'(evt_overflow), 64'd1);
        check_eq("ovf_head_ts", 64'(evt_data[15:0]), 64'd0);
        for (int i = 0; i < 8; i++) idle(1'b0, 1'b1, 1'b0);
        check_eq("drained", 64'(evt_valid), 64'd0);
        idle(1'b0, 1'b1, 1'b0);
        check_eq("pop_empty_ovf", 64'(evt_overflow), 64'd1);

        // Full FIFO with simultaneous push and pop
        idle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 20'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 20'h30000, 1'b0, 1'b1, 1'b0);
        check_eq("full_pp_ovf", 64'(evt_overflow), 64'd0);
        check_eq("full_pp_head_ts", 64'(evt_data[15:0]), 64'd1);
        for (int i = 0; i < 7; i++) idle(1'b0, 1'b1, 1'b0);
        check_eq("full_pp_tail", 64'(evt_data), 64'({2'b01, 20'h30000, 16'd8}));

        // cnt_clr with a cor event, then sclr mid-stream
        ed = 20'h00300;
        step(1'b1, 1'b1, 1'b0, 1'b0, ed, 1'b1, 1'b0, 1'b0);
        check_eq("clr_words", 64'(cnt_words), 64'd0);
        check_eq("clr_dig_hits", 64'(dig_hits), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 20'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 20'hFFFFF, 1'b0, 1'b0, 1'b1);
        check_eq("sclr_evt_valid", 64'(evt_valid), 64'd0);
        check_eq("sclr_dv", 64'(bus.datavalid_out), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0),
                 20'($urandom), 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
